instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: output buffer entries; legal values are powers of two ≥2.
REQ-002 Parameter CNT_W, default 8: width of err_count.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: an operation is presented on the in_* fields.
REQ-006 Port in_ready, output, 1: the encoder accepts the operation; a transfer occurs when in_valid && in_ready at a clock edge.
REQ-007 Port in_asm, input, instr_t: mnemonic enum, the same enum the decoder consumes.
REQ-008 Ports in_rd, in_rs1, in_rs2, input, 5 each: register indices.
REQ-009 Port in_imm, input, 32: immediate as a sign-extended byte value; for shifts it is shamt.
REQ-010 Port out_valid, output, 1: out_instr and out_err are valid.
REQ-011 Port out_ready, input, 1: the sink accepts; a transfer occurs when out_valid && out_ready at a clock edge.
REQ-012 Port out_instr, output, 32: encoded RV32I instruction word.
REQ-013 Port out_err, output, 1: the word is illegal or its immediate is out of range.
REQ-014 Port err_count, output, CNT_W: count of error words transferred on the output.

Function
REQ-015 Operation is a 2-stage pipeline: S1 registers the input fields; the instr_pack result of S1 is written into the FIFO.
REQ-016 Latency: fields accepted at edge N appear with out_valid=1 after edge N+1, provided the FIFO is not full.
REQ-017 S1 advances into the FIFO when S1 is valid and the FIFO is not full, or when the FIFO is full and is popped in the same cycle.
REQ-018 in_ready = !s1_valid || s1_advance; throughput is one word per cycle while out_ready=1.
REQ-019 The FIFO pointers wrap modulo FIFO_DEPTH; a simultaneous push and pop when full or empty keeps the count unchanged, and data is never lost or duplicated.
REQ-020 The encoding follows the RV32I base formats: U uses imm[31:12]; J uses imm[20|10:1|11|19:12]; I uses imm[11:0]; S uses imm[11:5] and imm[4:0]; B uses imm[12|10:5] and imm[4:1|11]; R uses funct7/funct3 per mnemonic.
REQ-021 For SLLI, SRLI and SRAI, imm[4:0] goes to [24:20], and funct7 is 0100000 for SRAI and 0 otherwise.
REQ-022 Fixed words: ECALL=0x00000073, EBREAK=0x00100073, FENCE=0x0FF0000F, FENCE_I=0x0000100F.
REQ-023 A mnemonic that is not in RV32I (including SUBI) or is an unknown enum value produces out_instr=0x00000000 with out_err=1, independent of any macro.
REQ-024 Ignored fields (for example rs2 for I-type) do not affect out_instr.
REQ-025 err_count increments on each output transfer with out_err=1 and saturates at all-ones.
REQ-026 The outputs hold stable while out_valid && !out_ready.

Reset
REQ-027 rst clears S1 valid, the FIFO pointers and err_count, and drives out_valid=0, in_ready=1, out_instr=0 and out_err=0, all asynchronously.
REQ-028 Reset asserted mid-operation discards all in-flight words; the first accept after reset deassertion follows REQ-016.

Configuration
REQ-029 Macro IMM_RANGE_CHECK_EN, when defined, enables range checking with out_err=1 on violation; the encoded word is still the truncated encoding.
REQ-030 Range rules: I/S immediates fit in signed 12 bits; B immediates are signed 13-bit and even; J immediates are signed 21-bit and even; U immediates have imm[11:0]=0; shift immediates are 0..31.
REQ-031 With the macro undefined, range violations are not flagged; only REQ-023 sets out_err.

Structure
REQ-032 The shared package rv_pkg holds instr_t, the opcode, funct3 and funct7 constants, and the fixed words of REQ-022.
REQ-033 The combinational field packer is the sub-module instr_pack, with asm/rd/rs1/rs2/imm in and instr/err out.
REQ-034 The sequential logic (S1, FIFO, counter) lives in instr_encoder.

Verification
REQ-035 ADDI rd=1 rs1=0 imm=5 -> out_instr=0x00500093, out_err=0, out_valid 2 edges after accept.
REQ-036 JAL rd=1 imm=8 -> 0x008000EF; BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
REQ-037 out_ready=0 and 5 back-to-back inputs, FIFO_DEPTH=2 -> exactly 3 accepted, then in_ready=0; release out_ready -> the 3 words emerge in order with no gaps.
REQ-038 Macro defined, ADDI imm=2048 -> out_err=1, out_instr=0x80000013 (rd=rs1=0), err_count=1 after the transfer; macro undefined -> out_err=0.
REQ-039 SUBI -> out_instr=0, out_err=1; ECALL/EBREAK -> fixed words of REQ-022.
REQ-040 Assert rst with 2 words buffered -> out_valid=0 immediately; after release the next input has latency 2 and there are no stale words.

Source files
------------

// File: rtl/rv_pkg.sv
// RV32I encoding vocabulary: mnemonic enum, opcode/funct constants, fixed words, format helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rv_pkg;

    typedef enum logic [5:0] {
        ASM_LUI, ASM_AUIPC, ASM_JAL, ASM_JALR,
        ASM_BEQ, ASM_BNE, ASM_BLT, ASM_BGE, ASM_BLTU, ASM_BGEU,
        ASM_LB, ASM_LH, ASM_LW, ASM_LBU, ASM_LHU,
        ASM_SB, ASM_SH, ASM_SW,
        ASM_ADDI, ASM_SLTI, ASM_SLTIU, ASM_XORI, ASM_ORI, ASM_ANDI,
        ASM_SLLI, ASM_SRLI, ASM_SRAI,
        ASM_ADD, ASM_SUB, ASM_SLL, ASM_SLT, ASM_SLTU,
        ASM_XOR, ASM_SRL, ASM_SRA, ASM_OR, ASM_AND,
        ASM_FENCE, ASM_FENCE_I, ASM_ECALL, ASM_EBREAK,
        ASM_SUBI    // not an RV32I instruction; always encodes as an error
    } instr_t;

    // Major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    // funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_B    = 3'b000;   // LB / SB
    localparam logic [2:0] F3_H    = 3'b001;   // LH / SH
    localparam logic [2:0] F3_W    = 3'b010;   // LW / SW
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;
    localparam logic [2:0] F3_ADD  = 3'b000;   // ADD/SUB/ADDI/JALR
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;   // SRL/SRA and immediates
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;   // SUB / SRA / SRAI

    // Words with no variable fields
    localparam logic [31:0] WORD_ECALL   = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] WORD_FENCE   = 32'h0FF0_000F;
    localparam logic [31:0] WORD_FENCE_I = 32'h0000_100F;

    // Encoder result as stored in the output buffer
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_t;

    function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm12, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] fmt_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OPC_STORE};
    endfunction

    // b holds imm[12:1]; imm[0] is implicitly zero in the branch format
    function automatic logic [31:0] fmt_b(input logic [11:0] b, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] fmt_u(input logic [19:0] imm20, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm20, rd, opc};
    endfunction

    // j holds imm[20:1]
    function automatic logic [31:0] fmt_j(input logic [19:0] j, input logic [4:0] rd);
        return {j[19], j[9:0], j[10], j[18:11], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: mnemonic + register indices + immediate -> 32-bit word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: asm (mnemonic), rd/rs1/rs2 (5b register indices), imm (32b byte-offset immediate or
//        shamt) in; instr (encoded word), err (illegal mnemonic, or immediate out of range when
//        IMM_RANGE_CHECK_EN is defined) out.
// Optional build macro: IMM_RANGE_CHECK_EN.
module instr_pack
    import rv_pkg::*;
(
    input  instr_t      asm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic illegal;

    always_comb begin
        instr   = 32'h0000_0000;
        illegal = 1'b0;
        case (asm)
            ASM_LUI:     instr = fmt_u(imm[31:12], rd, OPC_LUI);
            ASM_AUIPC:   instr = fmt_u(imm[31:12], rd, OPC_AUIPC);
            ASM_JAL:     instr = fmt_j(imm[20:1], rd);
            ASM_JALR:    instr = fmt_i(imm[11:0], rs1, F3_ADD, rd, OPC_JALR);

            ASM_BEQ:     instr = fmt_b(imm[12:1], rs2, rs1, F3_BEQ);
            ASM_BNE:     instr = fmt_b(imm[12:1], rs2, rs1, F3_BNE);
            ASM_BLT:     instr = fmt_b(imm[12:1], rs2, rs1, F3_BLT);
            ASM_BGE:     instr = fmt_b(imm[12:1], rs2, rs1, F3_BGE);
            ASM_BLTU:    instr = fmt_b(imm[12:1], rs2, rs1, F3_BLTU);
            ASM_BGEU:    instr = fmt_b(imm[12:1], rs2, rs1, F3_BGEU);

            ASM_LB:      instr = fmt_i(imm[11:0], rs1, F3_B,  rd, OPC_LOAD);
            ASM_LH:      instr = fmt_i(imm[11:0], rs1, F3_H,  rd, OPC_LOAD);
            ASM_LW:      instr = fmt_i(imm[11:0], rs1, F3_W,  rd, OPC_LOAD);
            ASM_LBU:     instr = fmt_i(imm[11:0], rs1, F3_BU, rd, OPC_LOAD);
            ASM_LHU:     instr = fmt_i(imm[11:0], rs1, F3_HU, rd, OPC_LOAD);

            ASM_SB:      instr = fmt_s(imm[11:0], rs2, rs1, F3_B);
            ASM_SH:      instr = fmt_s(imm[11:0], rs2, rs1, F3_H);
            ASM_SW:      instr = fmt_s(imm[11:0], rs2, rs1, F3_W);

            ASM_ADDI:    instr = fmt_i(imm[11:0], rs1, F3_ADD,  rd, OPC_OP_IMM);
            ASM_SLTI:    instr = fmt_i(imm[11:0], rs1, F3_SLT,  rd, OPC_OP_IMM);
            ASM_SLTIU:   instr = fmt_i(imm[11:0], rs1, F3_SLTU, rd, OPC_OP_IMM);
            ASM_XORI:    instr = fmt_i(imm[11:0], rs1, F3_XOR,  rd, OPC_OP_IMM);
            ASM_ORI:     instr = fmt_i(imm[11:0], rs1, F3_OR,   rd, OPC_OP_IMM);
            ASM_ANDI:    instr = fmt_i(imm[11:0], rs1, F3_AND,  rd, OPC_OP_IMM);

            // Shift immediates reuse the R layout with shamt in the rs2 slot
            ASM_SLLI:    instr = fmt_r(F7_BASE, imm[4:0], rs1, F3_SLL, rd, OPC_OP_IMM);
            ASM_SRLI:    instr = fmt_r(F7_BASE, imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM);
            ASM_SRAI:    instr = fmt_r(F7_ALT,  imm[4:0], rs1, F3_SR,  rd, OPC_OP_IMM);

            ASM_ADD:     instr = fmt_r(F7_BASE, rs2, rs1, F3_ADD,  rd, OPC_OP);
            ASM_SUB:     instr = fmt_r(F7_ALT,  rs2, rs1, F3_ADD,  rd, OPC_OP);
            ASM_SLL:     instr = fmt_r(F7_BASE, rs2, rs1, F3_SLL,  rd, OPC_OP);
            ASM_SLT:     instr = fmt_r(F7_BASE, rs2, rs1, F3_SLT,  rd, OPC_OP);
            ASM_SLTU:    instr = fmt_r(F7_BASE, rs2, rs1, F3_SLTU, rd, OPC_OP);
            ASM_XOR:     instr = fmt_r(F7_BASE, rs2, rs1, F3_XOR,  rd, OPC_OP);
            ASM_SRL:     instr = fmt_r(F7_BASE, rs2, rs1, F3_SR,   rd, OPC_OP);
            ASM_SRA:     instr = fmt_r(F7_ALT,  rs2, rs1, F3_SR,   rd, OPC_OP);
            ASM_OR:      instr = fmt_r(F7_BASE, rs2, rs1, F3_OR,   rd, OPC_OP);
            ASM_AND:     instr = fmt_r(F7_BASE, rs2, rs1, F3_AND,  rd, OPC_OP);

            ASM_FENCE:   instr = WORD_FENCE;
            ASM_FENCE_I: instr = WORD_FENCE_I;
            ASM_ECALL:   instr = WORD_ECALL;
            ASM_EBREAK:  instr = WORD_EBREAK;

            // ASM_SUBI and any value outside the enum land here: zero word, flagged
            default:     illegal = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be representable in the field it is truncated into.
    // "fits signed N bits" == imm[31:N-1] all zeros or all ones.
    logic range_bad;

    always_comb begin
        range_bad = 1'b0;
        case (asm)
            ASM_LUI, ASM_AUIPC:
                range_bad = (imm[11:0] != 12'h000);
            ASM_JAL:
                range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            ASM_BEQ, ASM_BNE, ASM_BLT, ASM_BGE, ASM_BLTU, ASM_BGEU:
                range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            ASM_JALR, ASM_LB, ASM_LH, ASM_LW, ASM_LBU, ASM_LHU,
            ASM_SB, ASM_SH, ASM_SW,
            ASM_ADDI, ASM_SLTI, ASM_SLTIU, ASM_XORI, ASM_ORI, ASM_ANDI:
                range_bad = !((&imm[31:11]) || !(|imm[31:11]));
            ASM_SLLI, ASM_SRLI, ASM_SRAI:
                range_bad = |imm[31:5];
            default:
                range_bad = 1'b0;
        endcase
    end

    assign err = illegal || range_bad;
`else
    assign err = illegal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: S1 field register -> instr_pack -> FIFO_DEPTH-entry output buffer.
// Latency: fields accepted at edge N are visible on out_* after edge N+1 (buffer not full).
// Backpressure: valid/ready both sides; S1 stalls while the buffer is full and not popped,
//               in_ready drops only then; outputs hold while out_valid && !out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready with in_asm, in_rd, in_rs1, in_rs2,
//        in_imm; out_valid/out_ready with out_instr, out_err; err_count (saturating count of
//        error words transferred). Parameters: FIFO_DEPTH (power of two >= 2), CNT_W.
// Optional build macro: IMM_RANGE_CHECK_EN (flags out-of-range immediates, see instr_pack).
module instr_encoder
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  instr_t           in_asm,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // ---------------- S1: registered input fields ----------------
    logic        s1_valid;
    instr_t      s1_asm;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    // ---------------- output buffer ----------------
    enc_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    enc_t          head;

    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          s1_advance;
    logic          accept;

    logic [31:0]   pack_instr;
    logic          pack_err;

    instr_pack u_pack (
        .asm   (s1_asm),
        .rd    (s1_rd),
        .rs1   (s1_rs1),
        .rs2   (s1_rs2),
        .imm   (s1_imm),
        .instr (pack_instr),
        .err   (pack_err)
    );

    assign fifo_full  = (count == FULL_CNT);
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    // A full buffer still takes S1 when its head leaves in the same cycle
    assign s1_advance = s1_valid && (!fifo_full || pop);
    assign push       = s1_advance;
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;

    // Buffer storage is not reset; emptiness is tracked by count and the outputs are gated.
    assign head      = mem[rd_ptr];
    assign out_instr = out_valid ? head.instr : 32'h0000_0000;
    assign out_err   = out_valid && head.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_asm   <= ASM_LUI;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_imm   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_asm   <= in_asm;
            s1_rd    <= in_rd;
            s1_rs1   <= in_rs1;
            s1_rs2   <= in_rs2;
            s1_imm   <= in_imm;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: pack_instr, err: pack_err};
        end
    end

    // Pointers are AW bits wide so they wrap modulo FIFO_DEPTH on their own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (pop && head.err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset state, latency, encoding table, backpressure,
// mid-operation reset and err_count saturation.
// Expected words are hand-computed RV32I encodings.
module tb_instr_encoder;
    import rv_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    instr_t      in_asm = ASM_ADDI;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    int n_vec  = 0;
    int n_fail = 0;
    int err_exp = 0;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_asm    (in_asm),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    typedef struct {
        instr_t      a;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input instr_t a, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1;
        in_asm   = a;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    // ADDI x1, x0, 5 with out_ready=1: invisible after the accept edge, visible after the next
    task automatic latency_test(input string tag);
        @(negedge clk);
        drive(ASM_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid_n"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_n1"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, 32'h0050_0093);
        chk({tag, "_err"}, 32'(out_err), 32'd0);
    endtask

    task automatic run_vec(input int i);
        int k;
        @(negedge clk);
        drive(tbl[i].a, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            n_vec++;
            n_fail++;
            $display("FAIL vec%0d_timeout: out_valid stayed 0, expected 1", i);
        end else begin
            chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].exp_instr);
            chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].exp_err));
            if (tbl[i].exp_err) err_exp++;
        end
    endtask

    initial begin
        int     idx;
        bit     acc;
        int     seen;
        instr_t bad_enum;

        bad_enum = instr_t'(6'd63);
        tbl.push_back('{ASM_LUI,    5'd5,  5'd0,  5'd0,  32'h1234_5000, 32'h1234_52B7, 1'b0});
        tbl.push_back('{ASM_AUIPC,  5'd2,  5'd0,  5'd0,  32'h0000_1000, 32'h0000_1117, 1'b0});
        tbl.push_back('{ASM_JAL,    5'd1,  5'd0,  5'd0,  32'd8,         32'h0080_00EF, 1'b0});
        tbl.push_back('{ASM_JALR,   5'd0,  5'd1,  5'd0,  32'd0,         32'h0000_8067, 1'b0});
        tbl.push_back('{ASM_BEQ,    5'd7,  5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0});
        tbl.push_back('{ASM_LW,     5'd5,  5'd2,  5'd31, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0});
        tbl.push_back('{ASM_SW,     5'd9,  5'd2,  5'd3,  32'd8,         32'h0031_2423, 1'b0});
        tbl.push_back('{ASM_SRAI,   5'd1,  5'd2,  5'd0,  32'd3,         32'h4031_5093, 1'b0});
        tbl.push_back('{ASM_SLLI,   5'd1,  5'd1,  5'd0,  32'd31,        32'h01F0_9093, 1'b0});
        tbl.push_back('{ASM_SRLI,   5'd2,  5'd3,  5'd0,  32'd0,         32'h0001_D113, 1'b0});
        tbl.push_back('{ASM_SUB,    5'd3,  5'd1,  5'd2,  32'hFFFF_FFFF, 32'h4020_81B3, 1'b0});
        tbl.push_back('{ASM_AND,    5'd10, 5'd11, 5'd12, 32'd0,         32'h00C5_F533, 1'b0});
        tbl.push_back('{ASM_ECALL,  5'd5,  5'd6,  5'd7,  32'd99,        32'h0000_0073, 1'b0});
        tbl.push_back('{ASM_EBREAK, 5'd0,  5'd0,  5'd0,  32'd0,         32'h0010_0073, 1'b0});
        tbl.push_back('{ASM_FENCE,  5'd0,  5'd0,  5'd0,  32'd0,         32'h0FF0_000F, 1'b0});
        tbl.push_back('{ASM_FENCE_I,5'd0,  5'd0,  5'd0,  32'd0,         32'h0000_100F, 1'b0});
        tbl.push_back('{ASM_SUBI,   5'd1,  5'd1,  5'd0,  32'd1,         32'h0000_0000, 1'b1});
        tbl.push_back('{bad_enum,   5'd1,  5'd1,  5'd1,  32'd1,         32'h0000_0000, 1'b1});
        tbl.push_back('{ASM_ADDI,   5'd1,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0093, 1'b0});
        tbl.push_back('{ASM_ADDI,   5'd0,  5'd0,  5'd0,  32'd2048,      32'h8000_0013, RC});
        tbl.push_back('{ASM_BEQ,    5'd0,  5'd0,  5'd0,  32'd3,         32'h0000_0163, RC});
        tbl.push_back('{ASM_SLLI,   5'd1,  5'd1,  5'd0,  32'd32,        32'h0000_9093, RC});
        tbl.push_back('{ASM_LUI,    5'd0,  5'd0,  5'd0,  32'h1234_5001, 32'h1234_5037, RC});

        // Reset state, observed while rst is held
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_instr", out_instr,      32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        latency_test("lat");

        foreach (tbl[i]) run_vec(i);
        @(negedge clk);
        chk("err_count_tbl", 32'(err_count), 32'(err_exp));

        // Backpressure: S1 plus two buffer entries absorb exactly three words
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) drive(ASM_ADDI, 5'(idx + 1), 5'd0, 5'd0, 32'(idx + 1));
            else         in_valid = 1'b0;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_instr", out_instr, 32'h0010_0093);
        out_ready = 1'b1;
        chk("bp_w1", out_instr, 32'h0010_0093);
        @(negedge clk);
        chk("bp_w2_valid", 32'(out_valid), 32'd1);
        chk("bp_w2", out_instr, 32'h0020_0113);
        @(negedge clk);
        chk("bp_w3_valid", 32'(out_valid), 32'd1);
        chk("bp_w3", out_instr, 32'h0030_0193);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two words buffered
        out_ready = 1'b0;
        drive(ASM_ADDI, 5'd4, 5'd0, 5'd0, 32'd4);
        @(posedge clk);
        @(negedge clk);
        drive(ASM_ADDI, 5'd5, 5'd0, 5'd0, 32'd5);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_buffered", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_instr", out_instr,      32'd0);
        chk("mid_rst_errc",  32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        latency_test("post_rst");
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_no_stale", 32'(seen), 32'd0);

        // Continuous error stream: full throughput and saturating counter
        drive(ASM_SUBI, 5'd1, 5'd1, 5'd0, 32'd1);
        repeat (2) @(negedge clk);
        seen = 0;
        repeat (280) begin
            if (out_valid && out_ready) seen++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream_throughput", 32'(seen), 32'd280);
        repeat (4) @(negedge clk);
        chk("err_count_sat", 32'(err_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
